// File: rtl/exec_ctrl_md_pkg.sv
// Shared constants for the EX-stage ALU control / mul-div block:
// ALU control codes, ALUOp classes, funct encodings and the engine state enum.
package exec_ctrl_pkg;

    // ALU control codes
    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_XOR     = 4'b0001;
    localparam logic [3:0] ALU_SLL     = 4'b0010;
    localparam logic [3:0] ALU_ADD     = 4'b0011;
    localparam logic [3:0] ALU_SUB     = 4'b0100;
    localparam logic [3:0] ALU_MUL     = 4'b0101;
    localparam logic [3:0] ALU_ADDI    = 4'b0110;
    localparam logic [3:0] ALU_SRAI    = 4'b0111;
    localparam logic [3:0] ALU_MEM     = 4'b1000;
    localparam logic [3:0] ALU_BR      = 4'b1001;
    localparam logic [3:0] ALU_DIV     = 4'b1010;
    localparam logic [3:0] ALU_DIVU    = 4'b1011;
    localparam logic [3:0] ALU_REM     = 4'b1100;
    localparam logic [3:0] ALU_REMU    = 4'b1101;
    localparam logic [3:0] ALU_INVALID = 4'b1111;

    // ALUOp classes from main control
    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    // {funct7, funct3} encodings
    localparam logic [9:0] F_AND  = 10'b0000000111;
    localparam logic [9:0] F_XOR  = 10'b0000000100;
    localparam logic [9:0] F_SLL  = 10'b0000000001;
    localparam logic [9:0] F_ADD  = 10'b0000000000;
    localparam logic [9:0] F_SUB  = 10'b0100000000;
    localparam logic [9:0] F_MUL  = 10'b0000001000;
    localparam logic [9:0] F_DIV  = 10'b0000001100;
    localparam logic [9:0] F_DIVU = 10'b0000001101;
    localparam logic [9:0] F_REM  = 10'b0000001110;
    localparam logic [9:0] F_REMU = 10'b0000001111;
    localparam logic [9:0] F_SRAI = 10'b0100000101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // True for codes handled by the sequential mul/div engine
    function automatic logic is_md_op(input logic [3:0] c);
        return (c == ALU_MUL) || ((c >= ALU_DIV) && (c <= ALU_REMU));
    endfunction

endpackage

// File: rtl/exec_ctrl_md_if.sv
// EX-stage bus between the pipeline and exec_ctrl_md.
// master = pipeline side, slave = exec_ctrl_md side.
interface exec_ctrl_md_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
);
    logic              valid_i;
    logic [9:0]        funct_i;
    logic [1:0]        ALUOp_i;
    logic              flush_i;
    logic [XLEN-1:0]   rs1_i;
    logic [XLEN-1:0]   rs2_i;
    logic [CTRL_W-1:0] ALUCtrl_o;
    logic              md_op_o;
    logic              busy_o;
    logic              done_o;
    logic [XLEN-1:0]   md_result_o;

    modport master (
        output valid_i, funct_i, ALUOp_i, flush_i, rs1_i, rs2_i,
        input  ALUCtrl_o, md_op_o, busy_o, done_o, md_result_o
    );

    modport slave (
        input  valid_i, funct_i, ALUOp_i, flush_i, rs1_i, rs2_i,
        output ALUCtrl_o, md_op_o, busy_o, done_o, md_result_o
    );
endinterface

// File: rtl/exec_ctrl_md_iter_core.sv
// md_iter_core: iterative multiply/divide engine (IDLE/RUN/DONE).
// MUL is shift-add; DIV/REM is restoring division on magnitudes with a sign
// fix-up at the end. Divide-by-zero and signed overflow bypass RUN.
// Optional macro FAST_MUL_EN: MUL is a single-cycle multiply (IDLE->DONE).
module md_iter_core
    import exec_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic            md_op_i,
    input  logic            flush_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN);

    md_state_e       state_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      op_q;
    logic [XLEN-1:0] a_q;     // multiplicand, or dividend shifting into quotient
    logic [XLEN-1:0] b_q;     // multiplier, or divisor magnitude
    logic [XLEN-1:0] acc_q;   // product accumulator, or partial remainder
    logic            negq_q, negr_q, done_q;
    logic [XLEN-1:0] res_q;

    logic            start, signed_op, sa, sb, div0, ovf, bypass;
    logic [XLEN-1:0] mag_a, mag_b, bypass_res;
    logic [XLEN-1:0] a_d, b_d, acc_d, fin_res;
    logic [XLEN:0]   rem_sh, rem_diff;
    logic            q_bit;

    // Flush beats a simultaneous start
    assign start  = (state_q == ST_IDLE) && valid_i && md_op_i && !flush_i;
    assign busy_o = start || (state_q == ST_RUN);
    assign done_o   = done_q;
    assign result_o = res_q;

    // Start-cycle operand prep and the special cases that skip RUN
    always_comb begin
        signed_op = (op_i == ALU_DIV) || (op_i == ALU_REM);
        sa    = signed_op && rs1_i[XLEN-1];
        sb    = signed_op && rs2_i[XLEN-1];
        mag_a = sa ? -rs1_i : rs1_i;
        mag_b = sb ? -rs2_i : rs2_i;
        div0  = (op_i != ALU_MUL) && (rs2_i == '0);
        ovf   = signed_op && (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
        bypass     = div0 || ovf;
        bypass_res = '0;
        if (div0)
            bypass_res = ((op_i == ALU_DIV) || (op_i == ALU_DIVU)) ? '1 : rs1_i;
        else if (ovf)
            bypass_res = (op_i == ALU_DIV) ? rs1_i : '0;
`ifdef FAST_MUL_EN
        if (op_i == ALU_MUL) begin
            bypass     = 1'b1;
            bypass_res = rs1_i * rs2_i;
        end
`endif
    end

    // One iteration step for the latched op, plus the sign-fixed final value
    always_comb begin
        rem_sh   = {acc_q, a_q[XLEN-1]};
        rem_diff = rem_sh - {1'b0, b_q};
        q_bit    = !rem_diff[XLEN];
        if (op_q == ALU_MUL) begin
            acc_d = b_q[0] ? (acc_q + a_q) : acc_q;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
        end else begin
            acc_d = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
            a_d   = {a_q[XLEN-2:0], q_bit};
            b_d   = b_q;
        end
        if (op_q == ALU_MUL)
            fin_res = acc_d;
        else if ((op_q == ALU_DIV) || (op_q == ALU_DIVU))
            fin_res = negq_q ? -a_d : a_d;
        else
            fin_res = negr_q ? -acc_d : acc_d;
    end

    // Engine FSM with registered done/result
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q  <= op_i;
                        cnt_q <= '0;
                        if (bypass) begin
                            res_q   <= bypass_res;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            a_q     <= (op_i == ALU_MUL) ? rs1_i : mag_a;
                            b_q     <= (op_i == ALU_MUL) ? rs2_i : mag_b;
                            acc_q   <= '0;
                            negq_q  <= sa ^ sb;
                            negr_q  <= sa;
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (flush_i) begin
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        a_q   <= a_d;
                        b_q   <= b_d;
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CW'(XLEN-1)) begin
                            res_q   <= fin_res;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/exec_ctrl_md.sv
// exec_ctrl_md: EX-stage ALU control decode plus iterative mul/div engine.
// Optional macro FAST_MUL_EN (handled in md_iter_core): single-cycle MUL.
module exec_ctrl_md
    import exec_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    exec_ctrl_md_if.slave bus
);
    logic [3:0] code;
    logic [2:0] funct3;

    assign funct3 = bus.funct_i[2:0];

    // Combinational {funct7,funct3}/ALUOp decode; unmatched maps to INVALID
    always_comb begin
        code = ALU_INVALID;
        case (bus.ALUOp_i)
            ALUOP_R: begin
                case (bus.funct_i)
                    F_AND:   code = ALU_AND;
                    F_XOR:   code = ALU_XOR;
                    F_SLL:   code = ALU_SLL;
                    F_ADD:   code = ALU_ADD;
                    F_SUB:   code = ALU_SUB;
                    F_MUL:   code = ALU_MUL;
                    F_DIV:   code = ALU_DIV;
                    F_DIVU:  code = ALU_DIVU;
                    F_REM:   code = ALU_REM;
                    F_REMU:  code = ALU_REMU;
                    default: code = ALU_INVALID;
                endcase
            end
            ALUOP_I: begin
                if (bus.funct_i == F_SRAI)
                    code = ALU_SRAI;
                else if ((funct3 == 3'b000) || (funct3 == 3'b010))
                    code = ALU_ADDI;
            end
            ALUOP_MEM: code = ALU_MEM;
            ALUOP_BR:  code = ALU_BR;
            default:   code = ALU_INVALID;
        endcase
    end

    assign bus.ALUCtrl_o = CTRL_W'(code);
    assign bus.md_op_o   = is_md_op(code);

    md_iter_core #(.XLEN(XLEN)) u_core (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (bus.valid_i),
        .md_op_i  (bus.md_op_o),
        .flush_i  (bus.flush_i),
        .op_i     (code),
        .rs1_i    (bus.rs1_i),
        .rs2_i    (bus.rs2_i),
        .busy_o   (bus.busy_o),
        .done_o   (bus.done_o),
        .result_o (bus.md_result_o)
    );

endmodule

// File: tb/tb_exec_ctrl_md.sv
// Bench for exec_ctrl_md (XLEN=32): decode sweep, directed mul/div corners,
// randomized mul/div against a plain-arithmetic model, flush and reset cases.
module tb_exec_ctrl_md;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    exec_ctrl_md_if #(.XLEN(XLEN), .CTRL_W(4)) bus ();

    exec_ctrl_md #(.XLEN(XLEN), .CTRL_W(4)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference result from the arithmetic rules of each op
    function automatic logic [31:0] ref_md(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic   ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (c)
            4'b0101: return a * b;
            4'b1010: return (b == 0) ? 32'hFFFF_FFFF : ov ? a : 32'(sa / sb);
            4'b1011: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'b1100: return (b == 0) ? a : ov ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Expected cycles from start to done_o (1 = skips the iterative path)
    function automatic int ref_lat(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        sgn = (c == 4'b1010) || (c == 4'b1100);
        if (c == 4'b0101) begin
`ifdef FAST_MUL_EN
            return 1;
`else
            return XLEN + 1;
`endif
        end
        if (b == 0) return 1;
        if (sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [9:0] funct_of(input logic [3:0] c);
        case (c)
            4'b0101: return 10'b0000001000;
            4'b1010: return 10'b0000001100;
            4'b1011: return 10'b0000001101;
            4'b1100: return 10'b0000001110;
            default: return 10'b0000001111;
        endcase
    endfunction

    // Issue one mul/div op; report cycles to done_o, busy cycles and result
    task automatic run_md(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt, output logic [31:0] res);
        @(negedge clk);
        bus.valid_i = 1'b1; bus.ALUOp_i = 2'b10; bus.funct_i = funct_of(c);
        bus.rs1_i = a; bus.rs2_i = b;
        #1;
        bcnt = bus.busy_o ? 1 : 0;
        @(negedge clk);
        bus.valid_i = 1'b0; bus.funct_i = 10'b0;
        lat = 1;
        while (!bus.done_o && lat < 200) begin
            if (bus.busy_o) bcnt++;
            @(negedge clk);
            lat++;
        end
        res = bus.md_result_o;
    endtask

    task automatic do_md(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int lat, bcnt, elat;
        logic [31:0] res, exp;
        exp  = ref_md(c, a, b);
        elat = ref_lat(c, a, b);
        run_md(c, a, b, lat, bcnt, res);
        chk({tag, " result"}, 64'(res), 64'(exp));
        chk({tag, " latency"}, 64'(lat), 64'(elat));
        chk({tag, " busy cycles"}, 64'(bcnt), 64'(elat));
        @(negedge clk);
        chk({tag, " done one cycle"}, 64'(bus.done_o), 64'(0));
        chk({tag, " result held"}, 64'(bus.md_result_o), 64'(exp));
    endtask

    typedef struct { logic [1:0] op; logic [9:0] f; logic [3:0] code; } dec_t;

    initial begin
        dec_t tbl[$];
        logic [3:0] mdc[5] = '{4'b0101, 4'b1010, 4'b1011, 4'b1100, 4'b1101};
        int lat, bcnt, dones;
        logic [31:0] res;

        bus.valid_i = 1'b0; bus.funct_i = '0; bus.ALUOp_i = '0; bus.flush_i = 1'b0;
        bus.rs1_i = '0; bus.rs2_i = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(bus.busy_o), 64'(0));
        chk("reset done", 64'(bus.done_o), 64'(0));
        chk("reset result", 64'(bus.md_result_o), 64'(0));
        rst_n = 1'b1;

        // Decode sweep (valid low so the engine stays idle)
        tbl.push_back('{2'b10, 10'b0000000111, 4'b0000});
        tbl.push_back('{2'b10, 10'b0000000100, 4'b0001});
        tbl.push_back('{2'b10, 10'b0000000001, 4'b0010});
        tbl.push_back('{2'b10, 10'b0000000000, 4'b0011});
        tbl.push_back('{2'b10, 10'b0100000000, 4'b0100});
        tbl.push_back('{2'b10, 10'b0000001000, 4'b0101});
        tbl.push_back('{2'b10, 10'b0000001100, 4'b1010});
        tbl.push_back('{2'b10, 10'b0000001101, 4'b1011});
        tbl.push_back('{2'b10, 10'b0000001110, 4'b1100});
        tbl.push_back('{2'b10, 10'b0000001111, 4'b1101});
        tbl.push_back('{2'b10, 10'b0000000010, 4'b1111});
        tbl.push_back('{2'b11, {7'($urandom), 3'b000}, 4'b0110});
        tbl.push_back('{2'b11, {7'($urandom), 3'b010}, 4'b0110});
        tbl.push_back('{2'b11, 10'b0100000101, 4'b0111});
        tbl.push_back('{2'b11, 10'b0000000101, 4'b1111});
        tbl.push_back('{2'b00, 10'($urandom), 4'b1000});
        tbl.push_back('{2'b01, 10'($urandom), 4'b1001});
        foreach (tbl[i]) begin
            @(negedge clk);
            bus.ALUOp_i = tbl[i].op; bus.funct_i = tbl[i].f;
            #1;
            chk($sformatf("decode %b/%b", tbl[i].op, tbl[i].f), 64'(bus.ALUCtrl_o), 64'(tbl[i].code));
            chk($sformatf("md_op %b/%b", tbl[i].op, tbl[i].f), 64'(bus.md_op_o),
                64'((tbl[i].code == 4'b0101) || (tbl[i].code >= 4'b1010 && tbl[i].code <= 4'b1101)));
        end

        // Directed cases with hand-computed results
        run_md(4'b0101, 32'd7, 32'hFFFF_FFFD, lat, bcnt, res);
        chk("mul 7*-3", 64'(res), 64'(32'hFFFF_FFEB));
`ifdef FAST_MUL_EN
        chk("mul latency", 64'(lat), 64'(1));
`else
        chk("mul latency", 64'(lat), 64'(33));
        chk("mul busy", 64'(bcnt), 64'(33));
`endif
        run_md(4'b1010, 32'hFFFF_FFF9, 32'd2, lat, bcnt, res);
        chk("div -7/2", 64'(res), 64'(32'hFFFF_FFFD));
        run_md(4'b1100, 32'hFFFF_FFF9, 32'd2, lat, bcnt, res);
        chk("rem -7%2", 64'(res), 64'(32'hFFFF_FFFF));
        run_md(4'b1011, 32'h8000_0000, 32'd3, lat, bcnt, res);
        chk("divu 0x80000000/3", 64'(res), 64'(32'h2AAA_AAAA));
        run_md(4'b1010, 32'd1234, 32'd0, lat, bcnt, res);
        chk("div by 0", 64'(res), 64'(32'hFFFF_FFFF));
        chk("div by 0 latency", 64'(lat), 64'(1));
        run_md(4'b1101, 32'hDEAD_BEEF, 32'd0, lat, bcnt, res);
        chk("remu x/0", 64'(res), 64'(32'hDEAD_BEEF));
        run_md(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt, res);
        chk("div overflow", 64'(res), 64'(32'h8000_0000));
        chk("div overflow latency", 64'(lat), 64'(1));
        run_md(4'b1100, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt, res);
        chk("rem overflow", 64'(res), 64'(32'h0));

        // Randomized ops against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [3:0]  c;
            logic [31:0] a, b;
            int sel;
            c   = mdc[$urandom_range(0, 4)];
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel < 4) b = 32'($signed(8'($urandom)));
            do_md($sformatf("rnd%0d op%b %h,%h", n, c, a, b), c, a, b);
        end

        // Flush at RUN step 5: back to IDLE, no done
        @(negedge clk);
        bus.valid_i = 1'b1; bus.ALUOp_i = 2'b10; bus.funct_i = funct_of(4'b1010);
        bus.rs1_i = 32'd1000; bus.rs2_i = 32'd7;
        @(negedge clk);
        bus.valid_i = 1'b0; bus.funct_i = 10'b0;
        repeat (5) @(negedge clk);
        chk("busy before flush", 64'(bus.busy_o), 64'(1));
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("flush busy", 64'(bus.busy_o), 64'(0));
        chk("flush done", 64'(bus.done_o), 64'(0));
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done_o) dones++;
        end
        chk("no done after flush", 64'(dones), 64'(0));
        // Flush beats a simultaneous start
        @(negedge clk);
        bus.valid_i = 1'b1; bus.flush_i = 1'b1; bus.funct_i = funct_of(4'b1010);
        @(negedge clk);
        bus.valid_i = 1'b0; bus.flush_i = 1'b0; bus.funct_i = 10'b0;
        chk("flush wins start", 64'(bus.busy_o), 64'(0));
        repeat (2) @(negedge clk);
        do_md("div after flush", 4'b1010, 32'hFFFF_FC18, 32'd7);

        // Reset mid-RUN abandons the op
        @(negedge clk);
        bus.valid_i = 1'b1; bus.ALUOp_i = 2'b10; bus.funct_i = funct_of(4'b1011);
        bus.rs1_i = 32'h1234_5678; bus.rs2_i = 32'd55;
        @(negedge clk);
        bus.valid_i = 1'b0; bus.funct_i = 10'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrun reset busy", 64'(bus.busy_o), 64'(0));
        chk("midrun reset done", 64'(bus.done_o), 64'(0));
        chk("midrun reset result", 64'(bus.md_result_o), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_md(4'b0101, 32'd3, 32'd4, lat, bcnt, res);
        chk("mul 3*4 after reset", 64'(res), 64'(12));
        chk("mul 3*4 latency", 64'(lat), 64'(ref_lat(4'b0101, 32'd3, 32'd4)));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
